// File: rtl/vertex_assembler_pkg.sv
// rtl/vertex_assembler_pkg.sv - shared types and screen-coordinate widths for the vertex assembler
package vertex_assembler_pkg;

  localparam int PKG_SCREEN_W = 160;
  localparam int PKG_SCREEN_H = 120;
  localparam int SX_W         = $clog2(PKG_SCREEN_W);
  localparam int SY_W         = $clog2(PKG_SCREEN_H);
  localparam int Z_W          = 8;

  typedef enum logic [1:0] {IDX_X, IDX_Y, IDX_Z, IDX_W} coord_idx_e;
  typedef enum logic [1:0] {V0, V1, V2} slot_e;

  typedef struct packed {
    logic [Z_W-1:0]  depth;
    logic [SY_W-1:0] sy;
    logic [SX_W-1:0] sx;
  } vertex_t;

  typedef struct packed {
    vertex_t v2;
    vertex_t v1;
    vertex_t v0;
  } tri_t;

  function automatic int clampRange(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vertex_assembler_if.sv
// rtl/vertex_assembler_if.sv - component input, triangle output and status bundle
interface vertex_assembler_if
  import vertex_assembler_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TRI_W  = $bits(tri_t)
);
  logic                     in_valid;
  logic [1:0]               in_idx;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     clear;
  logic                     tri_valid;
  logic [TRI_W-1:0]         tri_data;
  logic                     tri_ready;
  logic                     proto_err;
  logic [15:0]              cull_count;

  modport slave (
    input  in_valid, in_idx, in_data, clear, tri_ready,
    output in_ready, tri_valid, tri_data, proto_err, cull_count
  );

  modport master (
    output in_valid, in_idx, in_data, clear, tri_ready,
    input  in_ready, tri_valid, tri_data, proto_err, cull_count
  );
endinterface

// File: rtl/vertex_assembler_tri_fifo.sv
// rtl/vertex_assembler_tri_fifo.sv - synchronous FIFO with occupancy count for finished triangles
module tri_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr;

  function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= bump(wrPtr);
      if (pop) rdPtr <= bump(rdPtr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rdPtr];
  assign valid = (count != '0);
endmodule

// File: rtl/vertex_assembler.sv
// rtl/vertex_assembler.sv - viewport-maps NDC components and groups vertices into buffered triangles
// Optional back-face/degenerate culling: VERTEX_ASSEMBLER_CULL_EN
module vertex_assembler
  import vertex_assembler_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int TRI_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  vertex_assembler_if.slave bus
);
  localparam int ONE = 1 << FRAC_W;
  localparam int CW  = $clog2(TRI_DEPTH + 1);

  slot_e      slot;
  coord_idx_e expIdx;
  logic       pending, inReady, protoErr;
  vertex_t    cur, v0, v1, v2;
  tri_t       triIn, fifoHead;
  logic       fifoValid, accept, inOrder, take, closeTri, push, pop, culled;
  logic [CW-1:0] fifoCount;
  logic [15:0]   cullCount;
  logic signed [DATA_W-1:0] comp;
  logic [SX_W-1:0] sxNew;
  logic [SY_W-1:0] syNew;
  logic [Z_W-1:0]  depthNew;
  int xPix, yPix, zPix, nextLoad;

  assign comp = bus.in_data;

  // int intermediates comfortably hold (comp+ONE)*SCREEN_W for 16-bit inputs
  always_comb begin
    xPix     = ((int'(comp) + ONE) * SCREEN_W) >>> (FRAC_W + 1);
    yPix     = ((ONE - int'(comp)) * SCREEN_H) >>> (FRAC_W + 1);
    zPix     = (int'(comp) + ONE) >>> 1;
    sxNew    = SX_W'(clampRange(xPix, SCREEN_W - 1));
    syNew    = SY_W'(clampRange(yPix, SCREEN_H - 1));
    depthNew = Z_W'(clampRange(zPix, ONE - 1));
  end

  assign accept   = bus.in_valid && inReady;
  assign inOrder  = (bus.in_idx == expIdx);
  assign take     = accept && inOrder && !bus.clear;
  assign closeTri = take && (slot == V2) && (expIdx == IDX_W);
  assign push     = pending && !bus.clear && !culled;
  assign pop      = fifoValid && bus.tri_ready;
  assign triIn    = {v2, v1, v0};

  always_comb begin
    nextLoad = int'(fifoCount) + int'(push) - int'(pop) + int'(closeTri);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot     <= V0;
      expIdx   <= IDX_X;
      pending  <= 1'b0;
      inReady  <= 1'b0;
      protoErr <= 1'b0;
      cur      <= '0;
      v0       <= '0;
      v1       <= '0;
      v2       <= '0;
    end else begin
      inReady <= (nextLoad < TRI_DEPTH);
      pending <= closeTri;
      if (bus.clear) begin
        slot   <= V0;
        expIdx <= IDX_X;
      end else if (accept && !inOrder) begin
        protoErr <= 1'b1;
        expIdx   <= IDX_X;
      end else if (take) begin
        expIdx <= coord_idx_e'(expIdx + 2'd1);
        case (expIdx)
          IDX_X: cur.sx    <= sxNew;
          IDX_Y: cur.sy    <= syNew;
          IDX_Z: cur.depth <= depthNew;
          default: begin
            case (slot)
              V0: begin v0 <= cur; slot <= V1; end
              V1: begin v1 <= cur; slot <= V2; end
              default: begin v2 <= cur; slot <= V0; end
            endcase
          end
        endcase
      end
    end
  end

`ifdef VERTEX_ASSEMBLER_CULL_EN
  localparam int AW = SX_W + SY_W + 3;
  logic signed [AW-1:0] dx1, dy1, dx2, dy2, area;

  always_comb begin
    dx1    = AW'(v1.sx) - AW'(v0.sx);
    dy1    = AW'(v1.sy) - AW'(v0.sy);
    dx2    = AW'(v2.sx) - AW'(v0.sx);
    dy2    = AW'(v2.sy) - AW'(v0.sy);
    area   = dx1 * dy2 - dx2 * dy1;
    culled = area[AW-1] || (area == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cullCount <= '0;
    else if (pending && !bus.clear && culled && cullCount != 16'hFFFF) cullCount <= cullCount + 16'd1;
  end
`else
  assign culled    = 1'b0;
  assign cullCount = '0;
`endif

  tri_fifo #(.WIDTH($bits(tri_t)), .DEPTH(TRI_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (triIn),
    .pop   (pop),
    .rdata (fifoHead),
    .valid (fifoValid),
    .count (fifoCount)
  );

  assign bus.in_ready   = inReady;
  assign bus.tri_valid  = fifoValid;
  assign bus.tri_data   = fifoHead;
  assign bus.proto_err  = protoErr;
  assign bus.cull_count = cullCount;
endmodule
